truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
- Synthesisable, self-checking stimulus/response engine for small combinational logic blocks.
- Drives every input combination of an N-input DUT in ascending binary order and compares the 1-bit DUT output against a parameterised expected truth table.
- Counts mismatches and reports pass/fail.
- Replaces hand-written exhaustive-sweep benches; usable both in simulation and on-board as a built-in self-test wrapper.

Parameters:
- N_IN, 4, number of DUT inputs (1..8); sweep length is 2**N_IN vectors.
- EXP, 16'h0000, expected truth table, width 2**N_IN; EXP[k] is the expected output for vec == k.
- HOLD, 1, cycles each vector is held before sampling (>=1); gives DUT settle time.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  pulse/level; begins a sweep when sampled high in IDLE or DONE
- dut_out  in  1  DUT output under test
- vec  out  N_IN  stimulus to DUT; vec[N_IN-1] is the first-listed (MSB) input
- busy  out  1  high while sweeping
- done  out  1  high from sweep completion until next start or reset
- pass  out  1  done && (err_cnt == 0)
- err_cnt  out  N_IN+1  number of mismatching vectors, max 2**N_IN
- first_err_vec  out  N_IN  vec value of first mismatch
- first_err_valid  out  1  a mismatch has been recorded this sweep

Behaviour:
- Reset (rst_n low at rising edge):
  - state=IDLE; vec=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0; hold counter=0.
  - Applies in any state, including mid-sweep; the sweep is abandoned with no partial result.
- FSM states:
  - IDLE: start=1 -> RUN; vec=0, hold_cnt=0, err_cnt/first_err_* cleared, busy=1.
  - RUN: vec is held HOLD cycles. On the edge ending the HOLD-th cycle (hold_cnt == HOLD-1), dut_out is sampled and compared with EXP[vec].
    - On mismatch: err_cnt+1. If first_err_valid==0, first_err_vec=vec and first_err_valid=1.
    - If vec == 2**N_IN-1: -> DONE, busy=0, done=1, vec unchanged.
    - Else: vec+1, hold_cnt=0.
    - Otherwise: hold_cnt+1.
  - DONE: outputs frozen. start=1 -> RUN with the same clearing as from IDLE; done drops to 0 the same edge busy rises.
- Timing: start high at edge t -> vec=0 and busy=1 from t; last sample at edge t + 2**N_IN*HOLD; done=1 visible after that edge. Total busy cycles = 2**N_IN*HOLD.
- start while RUN is ignored; no restart, no effect on counters.
- err_cnt never wraps; width N_IN+1 holds the all-fail value 2**N_IN.
- pass is registered and consistent with done/err_cnt on the same cycle; it is never high while busy.
- dut_out is sampled only at sample edges; glitches between samples are ignored.
- vec is never X after reset; vec does not advance in IDLE/DONE.

Test Plan:
- N_IN=4, HOLD=1, EXP=16'hF888 (o=a&b | c&d), correct DUT; start pulse at cycle 2 -> vec steps 0..15 one per cycle, busy 16 cycles, done=1 at cycle 18, err_cnt=0, pass=1, first_err_valid=0.
- Same EXP, DUT stuck-at-0 -> err_cnt=7, first_err_vec=4'd3, first_err_valid=1, pass=0.
- HOLD=3, EXP=16'h6996 (XOR4), correct DUT -> each vec value held exactly 3 cycles, done after 48 busy cycles, pass=1; a DUT with 2-cycle output delay still passes.
- start re-pulsed at vec=5 mid-sweep -> no restart, sweep completes normally; start in DONE -> done falls, err_cnt cleared, new sweep from vec=0.
- rst_n low for one edge while vec=7 -> next cycle all outputs 0, state IDLE; subsequent start gives a full clean sweep.
- N_IN=2, HOLD=1, EXP=4'b1000 (AND2), DUT = OR2 -> err_cnt=2, first_err_vec=2'd1, done after 4 busy cycles.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Bus between the truth-table sweeper and whatever drives/observes it.
// The master side is the sweeper; the slave side supplies start and the DUT response.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 4
) ();
  logic            start;
  logic            dut_out;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] first_err_vec;
  logic            first_err_valid;

  modport master (
    input  start, dut_out,
    output vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
  );

  modport slave (
    output start, dut_out,
    input  vec, busy, done, pass, err_cnt, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus/response engine: sweeps every input vector of an N_IN-input
// combinational block, compares its 1-bit output with EXP and tallies mismatches.
module truth_table_sweeper #(
  parameter int unsigned           N_IN = 4,
  parameter logic [(2**N_IN)-1:0]  EXP  = '0,
  parameter int unsigned           HOLD = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  truth_table_sweeper_if.master bus
);

  localparam int unsigned EW = N_IN + 1;
  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state;
  logic [N_IN-1:0] r_vec, w_vec;
  logic [HW-1:0]   r_hold, w_hold;
  logic [EW-1:0]   r_err, w_err;
  logic [N_IN-1:0] r_fvec, w_fvec;
  logic            r_fval, w_fval;
  logic            r_busy, w_busy;
  logic            r_done, w_done;
  logic            r_pass, w_pass;

  // State and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
      r_hold  <= '0;
      r_err   <= '0;
      r_fvec  <= '0;
      r_fval  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_vec   <= w_vec;
      r_hold  <= w_hold;
      r_err   <= w_err;
      r_fvec  <= w_fvec;
      r_fval  <= w_fval;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
    end
  end

  // Next-state: start only acts from IDLE/DONE; compare happens on the last hold cycle
  always_comb begin
    w_state = r_state;
    w_vec   = r_vec;
    w_hold  = r_hold;
    w_err   = r_err;
    w_fvec  = r_fvec;
    w_fval  = r_fval;
    w_busy  = r_busy;
    w_done  = r_done;
    w_pass  = r_pass;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state = S_RUN;
          w_vec   = '0;
          w_hold  = '0;
          w_err   = '0;
          w_fvec  = '0;
          w_fval  = 1'b0;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_pass  = 1'b0;
        end
      end
      S_RUN: begin
        if (r_hold == HW'(HOLD - 1)) begin
          if (bus.dut_out != EXP[r_vec]) begin
            w_err = r_err + EW'(1);
            if (!r_fval) begin
              w_fvec = r_vec;
              w_fval = 1'b1;
            end
          end
          if (r_vec == '1) begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_pass  = (w_err == '0);
          end else begin
            w_vec  = r_vec + N_IN'(1);
            w_hold = '0;
          end
        end else begin
          w_hold = r_hold + HW'(1);
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.vec             = r_vec;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.err_cnt         = r_err;
  assign bus.first_err_vec   = r_fvec;
  assign bus.first_err_valid = r_fval;

endmodule
